// File: rtl/quad_encoder_array.sv
// Multi-channel x4 quadrature decoder: synchronizer, run-length glitch filter, position counter.
// Optional windowed velocity measurement is built only when QUAD_VELOCITY_EN is defined.
module quad_encoder_array #(
  parameter int NUM_CH     = 2,
  parameter int COUNT_W    = 32,
  parameter int FILTER_LEN = 5,
  parameter int VEL_WINDOW = 16000
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         quadA,
  input  logic [NUM_CH-1:0]         quadB,
  output logic [NUM_CH-1:0]         A_filtered,
  output logic [NUM_CH-1:0]         B_filtered,
  output logic [NUM_CH*COUNT_W-1:0] count,
  input  logic [NUM_CH-1:0]         load,
  input  logic [COUNT_W-1:0]        load_value,
  output logic [NUM_CH-1:0]         err,
  input  logic [NUM_CH-1:0]         err_clr,
  output logic [NUM_CH*COUNT_W-1:0] velocity,
  output logic                      vel_valid
);

  localparam logic [7:0]         RUN_LAST = 8'(FILTER_LEN - 1);
  localparam logic [8:0]         WARM_LEN = 9'(FILTER_LEN + 3);
  localparam logic [COUNT_W-1:0] STEP_UP  = COUNT_W'(1);

  if (NUM_CH < 1 || NUM_CH > 8 || COUNT_W < 8 || COUNT_W > 32 || FILTER_LEN < 1 ||
      FILTER_LEN > 255 || VEL_WINDOW < 2 || VEL_WINDOW > 2**24) begin : g_bad_cfg
    $error("quad_encoder_array: parameter out of range");
  end

  // Returns {new filtered level, new run count}; a level is accepted on the FILTER_LEN-th differing sample.
  function automatic logic [8:0] filt_f(input logic sync_lvl, input logic flt_lvl, input logic [7:0] run);
    logic [8:0] res;
    if (sync_lvl == flt_lvl) res = {flt_lvl, 8'd0};
    else if (run == RUN_LAST) res = {sync_lvl, 8'd0};
    else res = {flt_lvl, run + 8'd1};
    return res;
  endfunction

  // Returns {increment, decrement} for a {A,B} previous/current pair.
  function automatic logic [1:0] dir_f(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] res;
    case ({prev_ab, cur_ab})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: res = 2'b10;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: res = 2'b01;
      default:                            res = 2'b00;
    endcase
    return res;
  endfunction

  logic [8:0]        r_warm;
  logic              w_warm;
  logic [NUM_CH-1:0] w_inc;
  logic [NUM_CH-1:0] w_dec;

  assign w_warm = (r_warm != 9'd0);

  // Post-reset warm-up timer: filters track the synchronizers and decoding is held off.
  always_ff @(posedge CLK) begin
    if (reset) r_warm <= WARM_LEN;
    else if (w_warm) r_warm <= r_warm - 9'd1;
    else r_warm <= r_warm;
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic               r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic               r_a_flt, r_b_flt, r_a_prev, r_b_prev, r_err;
    logic [7:0]         r_a_run, r_b_run;
    logic [COUNT_W-1:0] r_count;
    logic [1:0]         w_dir;
    logic               w_ill;
    logic [8:0]         w_a_nxt, w_b_nxt;

    assign w_dir     = dir_f({r_a_prev, r_b_prev}, {r_a_flt, r_b_flt});
    assign w_inc[gi] = ~w_warm & w_dir[1];
    assign w_dec[gi] = ~w_warm & w_dir[0];
    assign w_ill     = ~w_warm & (r_a_prev ^ r_a_flt) & (r_b_prev ^ r_b_flt);
    assign w_a_nxt   = filt_f(r_a_s2, r_a_flt, r_a_run);
    assign w_b_nxt   = filt_f(r_b_s2, r_b_flt, r_b_run);

    // Per-channel synchronizer, filter, decoder history, position and sticky error.
    always_ff @(posedge CLK) begin
      if (reset) begin
        r_a_s1 <= 1'b0; r_a_s2 <= 1'b0; r_b_s1 <= 1'b0; r_b_s2 <= 1'b0;
        r_a_flt <= 1'b0; r_b_flt <= 1'b0; r_a_prev <= 1'b0; r_b_prev <= 1'b0;
        r_a_run <= 8'd0; r_b_run <= 8'd0;
        r_count <= {COUNT_W{1'b0}};
        r_err   <= 1'b0;
      end else begin
        r_a_s1 <= quadA[gi]; r_a_s2 <= r_a_s1;
        r_b_s1 <= quadB[gi]; r_b_s2 <= r_b_s1;
        if (w_warm) begin
          // history follows too, so the first decode after warm-up sees no edge
          r_a_flt <= r_a_s2; r_b_flt <= r_b_s2;
          r_a_prev <= r_a_s2; r_b_prev <= r_b_s2;
          r_a_run <= 8'd0; r_b_run <= 8'd0;
        end else begin
          {r_a_flt, r_a_run} <= w_a_nxt;
          {r_b_flt, r_b_run} <= w_b_nxt;
          r_a_prev <= r_a_flt; r_b_prev <= r_b_flt;
        end
        if (load[gi]) r_count <= load_value;
        else if (w_inc[gi]) r_count <= r_count + STEP_UP;
        else if (w_dec[gi]) r_count <= r_count - STEP_UP;
        else r_count <= r_count;
        if (w_ill) r_err <= 1'b1;
        else if (err_clr[gi]) r_err <= 1'b0;
        else r_err <= r_err;
      end
    end

    assign A_filtered[gi]                  = r_a_flt;
    assign B_filtered[gi]                  = r_b_flt;
    assign err[gi]                         = r_err;
    assign count[gi*COUNT_W +: COUNT_W]    = r_count;
  end

`ifdef QUAD_VELOCITY_EN
  localparam logic [24:0] WIN_LAST = 25'(VEL_WINDOW - 1);
  logic [24:0] r_win;
  logic        r_vel_valid;
  logic        w_win_tc;

  assign w_win_tc = (r_win == WIN_LAST);

  // Free-running sampling window.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_win       <= 25'd0;
      r_vel_valid <= 1'b0;
    end else begin
      r_win       <= w_win_tc ? 25'd0 : r_win + 25'd1;
      r_vel_valid <= w_win_tc;
    end
  end

  for (genvar gv = 0; gv < NUM_CH; gv++) begin : g_vel
    logic [COUNT_W-1:0] r_acc, r_vel, w_step;

    always_comb begin
      w_step = {COUNT_W{1'b0}};
      if (w_inc[gv]) w_step = STEP_UP;
      else if (w_dec[gv]) w_step = {COUNT_W{1'b1}};
      else w_step = {COUNT_W{1'b0}};
    end

    // Step accumulator, dumped into velocity at the window's terminal count.
    always_ff @(posedge CLK) begin
      if (reset) begin
        r_acc <= {COUNT_W{1'b0}};
        r_vel <= {COUNT_W{1'b0}};
      end else if (w_win_tc) begin
        r_vel <= r_acc + w_step;
        r_acc <= {COUNT_W{1'b0}};
      end else begin
        r_vel <= r_vel;
        r_acc <= r_acc + w_step;
      end
    end

    assign velocity[gv*COUNT_W +: COUNT_W] = r_vel;
  end

  assign vel_valid = r_vel_valid;
`else
  assign velocity  = {(NUM_CH*COUNT_W){1'b0}};
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_array.sv
// Self-checking bench for quad_encoder_array: directed steps plus random moves against a
// state-sequence position model; velocity checks follow QUAD_VELOCITY_EN.
module tb_quad_encoder_array;
  localparam int L = 5;

`ifdef QUAD_VELOCITY_EN
  localparam bit VEL_EN = 1'b1;
`else
  localparam bit VEL_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  quadA = 2'b00, quadB = 2'b00, load = 2'b00, err_clr = 2'b00;
  logic [7:0]  load_value = 8'h00;
  logic [1:0]  A_filtered, B_filtered, err;
  logic [15:0] count, velocity;
  logic        vel_valid;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] m_pos [2];
  logic       m_err [2];
  logic [1:0] m_ab  [2];
  logic [1:0] seq   [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_array #(.NUM_CH(2), .COUNT_W(8), .FILTER_LEN(L), .VEL_WINDOW(100)) dut (
    .CLK(CLK), .reset(reset), .quadA(quadA), .quadB(quadB),
    .A_filtered(A_filtered), .B_filtered(B_filtered), .count(count),
    .load(load), .load_value(load_value), .err(err), .err_clr(err_clr),
    .velocity(velocity), .vel_valid(vel_valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // position of a {A,B} state in the forward sequence 00,10,11,01
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] cnt_of(input int ch);
    return count[ch*8 +: 8];
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move channel ch to state ab; optionally strobe err_clr/load on the decode cycle.
  task automatic move(input int ch, input logic [1:0] ab, input bit clr_at, input bit load_at, input int hold);
    logic [1:0] old;
    int d;
    old = m_ab[ch];
    d = (gidx(ab) - gidx(old) + 4) % 4;
    quadA[ch] = ab[1];
    quadB[ch] = ab[0];
    repeat (L + 1) tick;
    chk("filt_hold", {A_filtered[ch], B_filtered[ch]}, old);
    tick;
    chk("filt_latency", {A_filtered[ch], B_filtered[ch]}, ab);
    chk("cnt_before_decode", cnt_of(ch), m_pos[ch]);
    if (clr_at) err_clr[ch] = 1'b1;
    if (load_at) load[ch] = 1'b1;
    tick;
    err_clr = 2'b00;
    load = 2'b00;
    if (load_at) m_pos[ch] = load_value;
    else if (d == 1) m_pos[ch] = m_pos[ch] + 8'd1;
    else if (d == 3) m_pos[ch] = m_pos[ch] - 8'd1;
    if (d == 2) m_err[ch] = 1'b1;
    else if (clr_at) m_err[ch] = 1'b0;
    m_ab[ch] = ab;
    chk("cnt", cnt_of(ch), m_pos[ch]);
    chk("err", err[ch], m_err[ch]);
    chk("other_cnt", cnt_of(1 - ch), m_pos[1 - ch]);
    chk("other_err", err[1 - ch], m_err[1 - ch]);
    repeat (hold) tick;
  endtask

  initial begin
    int eff_c, eff_d;
    logic [7:0] acc, exp_vel;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 8'h00; m_err[i] = 1'b0; m_ab[i] = 2'b00;
    end

    // reset state
    repeat (3) tick;
    chk("rst_count", count, 16'h0000);
    chk("rst_err", err, 2'b00);
    chk("rst_filt", {A_filtered, B_filtered}, 4'h0);
    chk("rst_velocity", velocity, 16'h0000);
    chk("rst_vel_valid", vel_valid, 1'b0);
    reset = 1'b0;
    repeat (L + 7) tick;
    chk("idle_count", count, 16'h0000);

    // four forward steps on channel 0
    move(0, 2'b10, 1'b0, 1'b0, 12);
    move(0, 2'b11, 1'b0, 1'b0, 12);
    move(0, 2'b01, 1'b0, 1'b0, 12);
    move(0, 2'b00, 1'b0, 1'b0, 12);
    chk("four_steps", cnt_of(0), 8'd4);

    // 4-cycle glitch rejected
    quadA[0] = 1'b1;
    repeat (4) begin tick; chk("glitch_filt", A_filtered[0], 1'b0); end
    quadA[0] = 1'b0;
    repeat (10) begin tick; chk("glitch_filt", A_filtered[0], 1'b0); end
    chk("glitch_cnt", cnt_of(0), m_pos[0]);

    // 5-cycle pulse accepted, then returns
    quadA[0] = 1'b1;
    repeat (5) tick;
    quadA[0] = 1'b0;
    repeat (2) tick;
    chk("pulse_filt", A_filtered[0], 1'b1);
    chk("pulse_cnt_hold", cnt_of(0), m_pos[0]);
    tick;
    chk("pulse_cnt_up", cnt_of(0), m_pos[0] + 8'd1);
    repeat (12) tick;
    chk("pulse_filt_back", A_filtered[0], 1'b0);
    chk("pulse_cnt_back", cnt_of(0), m_pos[0]);

    // illegal transition, clear, clear racing a new illegal one
    move(1, 2'b11, 1'b0, 1'b0, 12);
    err_clr[1] = 1'b1;
    tick;
    err_clr = 2'b00;
    m_err[1] = 1'b0;
    chk("err_clr", err[1], 1'b0);
    move(1, 2'b00, 1'b1, 1'b0, 12);

    // wrap at the 8-bit boundaries and load beating a step
    load_value = 8'h7F; load[0] = 1'b1; tick; load = 2'b00; m_pos[0] = 8'h7F;
    chk("load_7f", cnt_of(0), 8'h7F);
    move(0, 2'b10, 1'b0, 1'b0, 12);
    chk("wrap_up", cnt_of(0), 8'h80);
    load_value = 8'h80; load[0] = 1'b1; tick; load = 2'b00; m_pos[0] = 8'h80;
    move(0, 2'b00, 1'b0, 1'b0, 12);
    chk("wrap_down", cnt_of(0), 8'h7F);
    load_value = 8'h5A;
    move(0, 2'b10, 1'b0, 1'b1, 12);
    chk("load_wins", cnt_of(0), 8'h5A);

    // random moves, illegal jumps, clears and loads
    for (int k = 0; k < 40; k++) begin
      int ch;
      logic [1:0] flip;
      ch = $urandom_range(0, 1);
      flip = 2'($urandom_range(1, 3));
      load_value = 8'($urandom);
      move(ch, m_ab[ch] ^ flip, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom_range(4, 12));
    end

    // reset mid-operation with a non-zero count
    load_value = 8'd37; load[0] = 1'b1; tick; load = 2'b00;
    chk("pre_reset_cnt", cnt_of(0), 8'd37);
    quadA = 2'b11; quadB = 2'b11;
    reset = 1'b1;
    tick;
    chk("midrst_count", count, 16'h0000);
    chk("midrst_err", err, 2'b00);
    chk("midrst_filt", {A_filtered, B_filtered}, 4'h0);
    chk("midrst_velocity", velocity, 16'h0000);
    chk("midrst_vel_valid", vel_valid, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 8'h00; m_err[i] = 1'b0; m_ab[i] = 2'b11;
    end

    // warm-up with inputs at 11, then two velocity windows
    eff_c = -1; eff_d = 0; acc = 8'h00; exp_vel = 8'h00;
    for (int c = 1; c <= 205; c++) begin
      int dir;
      tick;
      if (c == eff_c) begin
        m_pos[0] = m_pos[0] + 8'(eff_d);
        acc = acc + 8'(eff_d);
      end
      if (VEL_EN && (c % 100 == 0)) begin
        exp_vel = acc;
        acc = 8'h00;
      end
      chk("win_cnt0", cnt_of(0), m_pos[0]);
      chk("win_cnt1", cnt_of(1), 8'h00);
      chk("win_err", err, 2'b00);
      chk("vel_valid", vel_valid, VEL_EN && (c % 100 == 0));
      chk("velocity0", velocity[7:0], exp_vel);
      chk("velocity1", velocity[15:8], 8'h00);
      dir = 0;
      if (c >= 9 && c <= 81 && (c - 9) % 8 == 0) dir = 1;
      else if (c >= 105 && c <= 121 && (c - 105) % 8 == 0) dir = -1;
      if (dir != 0) begin
        m_ab[0] = seq[(gidx(m_ab[0]) + dir + 4) % 4];
        quadA[0] = m_ab[0][1];
        quadB[0] = m_ab[0][0];
        eff_c = c + L + 3;
        eff_d = dir;
      end
    end
    chk("final_cnt", cnt_of(0), 8'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_encoder_array.md
QUAD_ENCODER_ARRAY -- requirements
Module: quad_encoder_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent encoder channels (1..8).
REQ-002 SHALL have parameter COUNT_W, default 32, signed position and velocity width (8..32).
REQ-003 SHALL have parameter FILTER_LEN, default 5, consecutive stable cycles required to accept an input level (1..255).
REQ-004 SHALL have parameter VEL_WINDOW, default 16000, velocity sampling window in CLK cycles (2..2^24).
REQ-005 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port quadA  input  NUM_CH  raw asynchronous encoder A, bit i = channel i.
REQ-008 SHALL have port quadB  input  NUM_CH  raw asynchronous encoder B.
REQ-009 SHALL have port A_filtered  output  NUM_CH  filtered A level.
REQ-010 SHALL have port B_filtered  output  NUM_CH  filtered B level.
REQ-011 SHALL have port count  output  NUM_CH*COUNT_W  signed position, channel i at [i*COUNT_W +: COUNT_W].
REQ-012 SHALL have port load  input  NUM_CH  per-channel single-cycle preset strobe.
REQ-013 SHALL have port load_value  input  COUNT_W  preset value shared by all channels.
REQ-014 SHALL have port err  output  NUM_CH  sticky illegal-transition flag.
REQ-015 SHALL have port err_clr  input  NUM_CH  per-channel error clear strobe.
REQ-016 SHALL have port velocity  output  NUM_CH*COUNT_W  signed steps per window, same packing as count.
REQ-017 SHALL have port vel_valid  output  1  one-cycle pulse when velocity updates.

Function
REQ-018 Each quadA/quadB bit SHALL pass a 2-flop synchronizer before any other use.
REQ-019 Filter: per signal, a run counter SHALL count cycles where synced level differs from filtered level; counter clears when levels match; filtered level takes synced level when counter reaches FILTER_LEN, counter clears.
REQ-020 Latency from a clean input level change to A_filtered/B_filtered change SHALL be exactly FILTER_LEN+2 cycles; to count change FILTER_LEN+3 cycles.
REQ-021 Decoder SHALL compare registered previous {A,B} filtered state with current, one decision per cycle.
REQ-022 Transitions 00->10, 10->11, 11->01, 01->00 SHALL increment count by 1 (x4 decoding).
REQ-023 Reverse transitions 00->01, 01->11, 11->10, 10->00 SHALL decrement count by 1.
REQ-024 Both bits changing in one cycle SHALL leave count unchanged and set err for that channel.
REQ-025 count SHALL wrap modulo 2^COUNT_W in two's complement (max+1 -> min, min-1 -> max), no saturation, no error.
REQ-026 load[i] SHALL set count channel i to load_value next cycle; a simultaneous step is discarded.
REQ-027 err_clr[i] SHALL clear err[i] next cycle; a simultaneous new illegal transition wins (err stays 1).
REQ-028 Channels SHALL be fully independent; activity on one never alters another.

Reset
REQ-029 While reset is high, at the next edge: count, velocity, err, vel_valid, A_filtered, B_filtered, synchronizers, filter counters, window counter, accumulators SHALL be 0.
REQ-030 Warm-up: for FILTER_LEN+3 cycles after reset deasserts, filtered levels SHALL follow synced levels directly, with no counting and no err setting.
REQ-031 Reset asserted mid-operation SHALL abort any filter run, window or pending load without residual effect.

Configuration
REQ-032 Macro QUAD_VELOCITY_EN defined: a window counter SHALL run 0..VEL_WINDOW-1; per-channel accumulators sum signed steps; on terminal count, velocity <= accumulator plus this cycle's step, accumulator <= 0, vel_valid = 1 for one cycle; load does not affect accumulators.
REQ-033 Macro QUAD_VELOCITY_EN undefined: velocity and vel_valid SHALL be constant 0 and no window or accumulator logic is synthesized.

Verification
REQ-034 NUM_CH=2, FILTER_LEN=5: drive ch0 00->10->11->01->00 with 20-cycle spacing -> count[0]=4, count[1]=0, each step FILTER_LEN+3=8 cycles after input edge.
REQ-035 4-cycle glitch on quadA[0] -> A_filtered[0] unchanged, count unchanged; 5-cycle pulse -> accepted.
REQ-036 Step ch1 from 00 to 11 in one cycle -> count[1] unchanged, err[1]=1; err_clr[1] -> err[1]=0 next cycle; err_clr with simultaneous illegal step -> err[1] stays 1.
REQ-037 COUNT_W=8, load_value=8'h7F, load, one forward step -> count=8'h80; load_value=8'h80, reverse step -> 8'h7F; load with simultaneous step -> load_value exactly.
REQ-038 QUAD_VELOCITY_EN, VEL_WINDOW=100, 10 forward steps inside one window -> vel_valid single pulse at cycle 100, velocity[0]=10; next window reverse 3 -> velocity[0]=-3.
REQ-039 Assert reset mid-window with count=37 -> all outputs 0 next edge; inputs held 11 through warm-up -> count stays 0, err stays 0.
